// File: rtl/puf_soc_piso_mlane_if.sv
// Frame-in / beat-out bundle for the multi-lane PUF response framer.
interface puf_soc_piso_mlane_if #(
    parameter int FRAM_SIZE = 160,
    parameter int LANES     = 1
);
    logic                 i_tx_en;
    logic                 i_tx_valid;
    logic [FRAM_SIZE-1:0] i_tx_data;
    logic                 i_tx_mode;
    logic                 i_tx_msb_first;
    logic                 o_tx_ready;
    logic                 i_tx_ready;
    logic [LANES-1:0]     o_tx_data;
    logic [LANES-1:0]     o_tx_keep;
    logic                 o_tx_valid;
    logic                 o_tx_last;
    logic                 o_tx_done;
    logic                 o_busy;

    modport master (
        output i_tx_en, i_tx_valid, i_tx_data, i_tx_mode,
        output i_tx_msb_first, i_tx_ready,
        input  o_tx_ready, o_tx_data, o_tx_keep, o_tx_valid,
        input  o_tx_last, o_tx_done, o_busy
    );

    modport slave (
        input  i_tx_en, i_tx_valid, i_tx_data, i_tx_mode,
        input  i_tx_msb_first, i_tx_ready,
        output o_tx_ready, o_tx_data, o_tx_keep, o_tx_valid,
        output o_tx_last, o_tx_done, o_busy
    );
endinterface

// File: rtl/puf_soc_piso_mlane.sv
// Multi-lane PISO framer: 2-deep frame queue feeding a beat shifter.
module puf_soc_piso_mlane #(
    parameter int FRAM_SIZE = 160,
    parameter int NORM_MOD  = 34,
    parameter int DEBUG_MOD = 133,
    parameter int LANES     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    puf_soc_piso_mlane_if.slave bus
);
    localparam int MAX_L = (NORM_MOD > DEBUG_MOD) ? NORM_MOD : DEBUG_MOD;
    localparam int MAX_B = (MAX_L + LANES - 1) / LANES;
    localparam int BW    = $clog2(MAX_B) + 1;
    localparam int PW    = (FRAM_SIZE > 1) ? $clog2(FRAM_SIZE) : 1;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [FRAM_SIZE-1:0] q_data_q [2];
    logic [1:0]           q_mode_q;
    logic [1:0]           q_msb_q;
    logic                 wr_ptr_q;
    logic                 rd_ptr_q;
    logic [1:0]           cnt_q, cnt_d;
    logic                 rdy_q;

    logic [0:0]           state_q, state_d;
    logic [FRAM_SIZE-1:0] sh_data_q;
    logic                 sh_mode_q;
    logic                 sh_msb_q;
    logic [BW-1:0]        beat_q, beat_d;
    logic                 done_q;

    logic                 push, pop, acc, last, start_ok;
    logic [LANES-1:0]     lane_data, lane_keep;
    logic [PW-1:0]        pos;
    int                   len, nbeats, idx;

    // Lane k of beat j carries stream bit j*LANES+k; MSB-first mirrors within L.
    always_comb begin
        lane_data = '0;
        lane_keep = '0;
        pos       = '0;
        idx       = 0;
        len       = sh_mode_q ? DEBUG_MOD : NORM_MOD;
        nbeats    = (len + LANES - 1) / LANES;
        for (int k = 0; k < LANES; k++) begin
            idx = int'(beat_q) * LANES + k;
            if (idx < len) begin
                pos          = PW'(sh_msb_q ? (len - 1 - idx) : idx);
                lane_data[k] = sh_data_q[pos];
                lane_keep[k] = 1'b1;
            end
        end
        last = (state_q == SHIFT) && (int'(beat_q) == nbeats - 1);
    end

    assign acc      = (state_q == SHIFT) && bus.i_tx_ready;
    assign start_ok = (cnt_q != 2'd0) && bus.i_tx_en;
    assign push     = bus.i_tx_valid && rdy_q;
    assign pop      = start_ok && ((state_q == IDLE) || (acc && last));

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        if (pop) begin
            state_d = SHIFT;
            beat_d  = '0;
        end else if (acc && last) begin
            state_d = IDLE;
        end else if (acc) begin
            beat_d = beat_q + 1'b1;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_data_q[0] <= '0;
            q_data_q[1] <= '0;
            q_mode_q    <= '0;
            q_msb_q     <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            cnt_q       <= '0;
            rdy_q       <= 1'b1;
            state_q     <= IDLE;
            sh_data_q   <= '0;
            sh_mode_q   <= 1'b0;
            sh_msb_q    <= 1'b0;
            beat_q      <= '0;
            done_q      <= 1'b0;
        end else begin
            if (push) begin
                q_data_q[wr_ptr_q] <= bus.i_tx_data;
                q_mode_q[wr_ptr_q] <= bus.i_tx_mode;
                q_msb_q[wr_ptr_q]  <= bus.i_tx_msb_first;
                wr_ptr_q           <= ~wr_ptr_q;
            end
            if (pop) begin
                sh_data_q <= q_data_q[rd_ptr_q];
                sh_mode_q <= q_mode_q[rd_ptr_q];
                sh_msb_q  <= q_msb_q[rd_ptr_q];
                rd_ptr_q  <= ~rd_ptr_q;
            end
            cnt_q   <= cnt_d;
            rdy_q   <= (cnt_d != 2'd2);
            state_q <= state_d;
            beat_q  <= beat_d;
            done_q  <= acc && last;
        end
    end

    assign bus.o_tx_ready = rdy_q;
    assign bus.o_tx_valid = (state_q == SHIFT);
    assign bus.o_tx_data  = (state_q == SHIFT) ? lane_data : '0;
    assign bus.o_tx_keep  = (state_q == SHIFT) ? lane_keep : '0;
    assign bus.o_tx_last  = last;
    assign bus.o_tx_done  = done_q;
    assign bus.o_busy     = (cnt_q != 2'd0) || (state_q == SHIFT);
endmodule

// File: tb/tb_puf_soc_piso_mlane.sv
// Scoreboard bench for puf_soc_piso_mlane with four lanes.
module tb_puf_soc_piso_mlane;
    localparam int FS = 160;
    localparam int NM = 34;
    localparam int DM = 133;
    localparam int LN = 4;

    typedef struct {
        logic [FS-1:0] s;
        int            len;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    puf_soc_piso_mlane_if #(.FRAM_SIZE(FS), .LANES(LN)) bus ();

    puf_soc_piso_mlane #(
        .FRAM_SIZE(FS),
        .NORM_MOD (NM),
        .DEBUG_MOD(DM),
        .LANES    (LN)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int checks = 0;
    int failures = 0;
    int beat = 0;
    int dones = 0;
    bit done_exp = 0;
    bit gap_exp = 0;
    logic [LN-1:0] first_data, last_data, last_keep;
    exp_t sbq[$];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic timeout_fail(string nm);
        checks++;
        failures++;
        $display("FAIL %s timed out", nm);
    endtask

    // Transmission-order bit stream for a frame, built straight from the lane map.
    function automatic exp_t mk(logic [FS-1:0] d, logic mode, logic msb);
        exp_t e;
        e.len = mode ? DM : NM;
        e.s   = '0;
        for (int i = 0; i < e.len; i++)
            e.s[i] = msb ? d[e.len-1-i] : d[i];
        return e;
    endfunction

    task automatic load(logic [FS-1:0] d, logic mode, logic msb);
        int t = 0;
        bus.i_tx_valid     = 1'b1;
        bus.i_tx_data      = d;
        bus.i_tx_mode      = mode;
        bus.i_tx_msb_first = msb;
        while (!bus.o_tx_ready && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) begin
            timeout_fail("load");
            bus.i_tx_valid = 1'b0;
        end else begin
            sbq.push_back(mk(d, mode, msb));
            @(posedge clk);
            #1;
            bus.i_tx_valid     = 1'b0;
            bus.i_tx_mode      = ~mode;
            bus.i_tx_msb_first = ~msb;
            bus.i_tx_data      = ~d;
        end
    endtask

    task automatic drain();
        int t = 0;
        while ((sbq.size() != 0 || bus.o_busy) && t < 2000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 2000) timeout_fail("drain");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_beat(int n);
        int t = 0;
        while (beat != n && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 1000) timeout_fail("wait_beat");
    endtask

    always @(negedge clk) begin : mon
        logic [LN-1:0] ed, ek;
        logic el;
        int nb, idx;
        if (!rst_n) begin
            sbq.delete();
            beat = 0;
            done_exp = 0;
            gap_exp = 0;
        end else begin
            chk("done_pulse", 64'(bus.o_tx_done), 64'(done_exp));
            if (bus.o_tx_done) dones++;
            if (gap_exp) chk("no_gap", 64'(bus.o_tx_valid), 64'(1));
            done_exp = 0;
            gap_exp = 0;
            if (bus.o_tx_valid) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL valid_without_frame data=%h", bus.o_tx_data);
                end else begin
                    nb = (sbq[0].len + LN - 1) / LN;
                    ed = '0;
                    ek = '0;
                    for (int k = 0; k < LN; k++) begin
                        idx = beat * LN + k;
                        if (idx < sbq[0].len) begin
                            ed[k] = sbq[0].s[idx];
                            ek[k] = 1'b1;
                        end
                    end
                    el = (beat == nb - 1);
                    chk("beat_last_keep_data",
                        64'({bus.o_tx_last, bus.o_tx_keep, bus.o_tx_data}),
                        64'({el, ek, ed}));
                    if (bus.i_tx_ready) begin
                        if (beat == 0) first_data = bus.o_tx_data;
                        if (el) begin
                            last_data = bus.o_tx_data;
                            last_keep = bus.o_tx_keep;
                            void'(sbq.pop_front());
                            beat = 0;
                            done_exp = 1;
                            gap_exp = (sbq.size() > 0) && bus.i_tx_en;
                        end else begin
                            beat++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [FS-1:0] rf;
        int d0;
        bus.i_tx_en        = 1'b0;
        bus.i_tx_valid     = 1'b0;
        bus.i_tx_data      = '0;
        bus.i_tx_mode      = 1'b0;
        bus.i_tx_msb_first = 1'b0;
        bus.i_tx_ready     = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ready", 64'(bus.o_tx_ready), 64'(1));
        chk("reset_outs", 64'({bus.o_tx_valid, bus.o_tx_last, bus.o_tx_done,
            bus.o_busy, bus.o_tx_keep, bus.o_tx_data}), 64'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Normal LSB-first frame, latency and hand-computed end beats.
        bus.i_tx_en = 1'b1;
        d0 = dones;
        load(160'h2_DEAD_BEEF, 1'b0, 1'b0);
        chk("lat_load_cycle_valid", 64'(bus.o_tx_valid), 64'(0));
        chk("lat_load_cycle_busy", 64'(bus.o_busy), 64'(1));
        @(posedge clk);
        #1;
        chk("lat_first_valid", 64'(bus.o_tx_valid), 64'(1));
        drain();
        chk("t1_first_beat", 64'(first_data), 64'(4'hF));
        chk("t1_last_data", 64'(last_data), 64'(4'b0010));
        chk("t1_last_keep", 64'(last_keep), 64'(4'b0011));
        chk("t1_done_count", 64'(dones), 64'(d0 + 1));

        // Debug MSB-first random frame.
        rf = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        d0 = dones;
        load(rf, 1'b1, 1'b1);
        drain();
        chk("t2_last_keep", 64'(last_keep), 64'(4'b0001));
        chk("t2_last_data", 64'(last_data), 64'({3'b000, rf[0]}));
        chk("t2_done_count", 64'(dones), 64'(d0 + 1));

        // Back-pressure for 5 cycles at beat 12 of a debug frame.
        rf = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        d0 = dones;
        load(rf, 1'b1, 1'b0);
        wait_beat(12);
        bus.i_tx_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("bp_hold_beat", 64'(beat), 64'(12));
        chk("bp_hold_valid", 64'(bus.o_tx_valid), 64'(1));
        bus.i_tx_ready = 1'b1;
        drain();
        chk("t3_done_count", 64'(dones), 64'(d0 + 1));

        // Three back-to-back frames of mixed mode and order.
        d0 = dones;
        load(160'h1_2345_6789, 1'b0, 1'b0);
        load({$urandom(), $urandom(), $urandom(), $urandom(), $urandom()}, 1'b1, 1'b1);
        load(160'h3_0F0F_1234, 1'b0, 1'b1);
        chk("b2b_ready_full", 64'(bus.o_tx_ready), 64'(0));
        drain();
        chk("t4_done_count", 64'(dones), 64'(d0 + 3));

        // Enable low with two frames queued.
        bus.i_tx_en = 1'b0;
        d0 = dones;
        load(160'h0_AAAA_5555, 1'b0, 1'b1);
        load(160'h2_5A5A_C3C3, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("en0_valid", 64'(bus.o_tx_valid), 64'(0));
        chk("en0_busy", 64'(bus.o_busy), 64'(1));
        chk("en0_ready", 64'(bus.o_tx_ready), 64'(0));
        bus.i_tx_en = 1'b1;
        @(posedge clk);
        #1;
        chk("en1_start", 64'(bus.o_tx_valid), 64'(1));
        drain();
        chk("t5_done_count", 64'(dones), 64'(d0 + 2));

        // Reset at beat 20 of a debug frame, then a fresh normal frame.
        rf = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        d0 = dones;
        load(rf, 1'b1, 1'b0);
        wait_beat(20);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_ready", 64'(bus.o_tx_ready), 64'(1));
        chk("rst_outs", 64'({bus.o_tx_valid, bus.o_tx_last, bus.o_tx_done,
            bus.o_busy, bus.o_tx_keep, bus.o_tx_data}), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_no_done", 64'(dones), 64'(d0));
        chk("rst_idle", 64'({bus.o_tx_valid, bus.o_busy}), 64'(0));
        load(160'h3_0F0F_1234, 1'b0, 1'b1);
        drain();
        chk("t6_done_count", 64'(dones), 64'(d0 + 1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
